// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand sequencer.
package systolic_pkg;

    // Sequencer states, see the table in systolic_feeder.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ARR,
        S_W_FEED,
        S_A_FEED,
        S_CAPTURE,
        S_OUT
    } state_t;

    // Default lane word; the top carries its own DW parameter for the ports.
    localparam int WORD_W = 8;
    typedef logic [WORD_W-1:0] word_t;

    // Phase and fill counters must reach 2N (A_FEED length) without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed per-lane delay line used to stagger activation lanes in time.
module skew_delay #(
    parameter int DW    = 8,
    parameter int DEPTH = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        // Lane 0 has no skew; clock and reset are intentionally left idle.
        logic tie_unused;
        assign tie_unused = clk ^ rst;
        assign dout       = din;
    end else begin : g_pipe
        logic [DW-1:0] stage [DEPTH];

        // Shift register; cleared on reset so no stale lane data reaches the array.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            end else begin
                stage[0] <= din;
                for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for an N x N systolic array: buffers weights and
// activations, replays weights, skews activations, captures results and
// either returns them to the host or chains them into the next pass.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | host loads weight/activation beats, waits for go
// S_WAIT_ARR | waits for arr_ready, then pulses arr_start
// S_W_FEED   | N cycles of weight beats on arr_w
// S_A_FEED   | 2N cycles of skewed activations on arr_a
// S_CAPTURE  | collects result words until arr_done
// S_OUT      | returns N result beats to the host
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_w_valid,
    output logic            ld_w_ready,
    input  logic [DW*N-1:0] ld_w_data,
    input  logic            ld_a_valid,
    output logic            ld_a_ready,
    input  logic [DW*N-1:0] ld_a_data,
    input  logic [PW-1:0]   cfg_passes,
    input  logic            go,
    output logic            busy,
    output logic            err,
    output logic            arr_start,
    input  logic            arr_ready,
    input  logic            arr_done,
    output logic [DW*N-1:0] arr_a,
    output logic [DW*N-1:0] arr_w,
    input  logic [DW*N-1:0] arr_y,
    input  logic            arr_y_valid,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW*N-1:0] res_data,
    output logic            res_last
);

    localparam int CW = cnt_width(N);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = DW * N;

    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_NM1  = CW'(N - 1);
    localparam logic [CW-1:0] CNT_2NM1 = CW'(2 * N - 1);

    state_t        state, state_nx;

    logic [BW-1:0] w_buf    [N];
    logic [BW-1:0] a_buf    [N];
    logic [BW-1:0] r_buf    [N];
    logic [BW-1:0] r_buf_nx [N];

    logic [CW-1:0] w_cnt;
    logic [CW-1:0] a_cnt;
    logic [CW-1:0] tmr;
    logic [CW-1:0] cap_cnt;
    logic [CW-1:0] cap_cnt_nx;
    logic [CW-1:0] out_k;
    logic [CW-1:0] a_t;
    logic [IW-1:0] w_idx;
    logic [PW-1:0] passes_left;
    logic          err_q;

    logic          w_hs;
    logic          a_hs;
    logic          go_ok;
    logic          cap_en;
    logic          cap_ovf;
    logic          done_cap;
    logic          done_early;
    logic          done_short;
    logic          chain;
    logic          res_hs;
    logic          out_last_hs;

    logic [BW-1:0] skew_src;
    logic [BW-1:0] skew_out;

    // Timer counts down through each feed phase; phase-relative cycle index derived from it.
    assign w_idx = IW'(CNT_NM1 - tmr);
    assign a_t   = CNT_2NM1 - tmr;

    assign w_hs        = ld_w_valid && ld_w_ready;
    assign a_hs        = ld_a_valid && ld_a_ready;
    assign go_ok       = (state == S_IDLE) && go && (w_cnt == CNT_N) && (a_cnt == CNT_N);
    assign cap_en      = arr_y_valid && ((state == S_A_FEED) || (state == S_CAPTURE));
    assign done_cap    = arr_done && (state == S_CAPTURE);
    assign done_early  = arr_done && ((state == S_WAIT_ARR) || (state == S_W_FEED) ||
                                      (state == S_A_FEED));
    assign done_short  = done_cap && (cap_cnt_nx < CNT_N);
    assign chain       = done_cap && (passes_left > PW'(1));
    assign res_hs      = res_valid && res_ready;
    assign out_last_hs = res_hs && (out_k == CNT_NM1);

    // Unskewed activation beat t enters every lane's delay line during the first N A_FEED cycles.
    assign skew_src = ((state == S_A_FEED) && (a_t < CNT_N)) ? a_buf[IW'(a_t)] : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay #(
            .DW    (DW),
            .DEPTH (i)
        ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (skew_src[DW*i +: DW]),
            .dout (skew_out[DW*i +: DW])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and array/host-facing outputs.
    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        ld_w_ready = 1'b0;
        ld_a_ready = 1'b0;
        arr_start  = 1'b0;
        arr_w      = '0;
        arr_a      = '0;
        res_valid  = 1'b0;
        res_data   = '0;
        res_last   = 1'b0;
        case (state)
            S_IDLE: begin
                ld_w_ready = (w_cnt != CNT_N);
                ld_a_ready = (a_cnt != CNT_N);
                if (go_ok) state_nx = S_WAIT_ARR;
            end
            S_WAIT_ARR: begin
                arr_start = arr_ready;
                if (arr_ready) state_nx = S_W_FEED;
            end
            S_W_FEED: begin
                arr_w = w_buf[w_idx];
                if (tmr == '0) state_nx = S_A_FEED;
            end
            S_A_FEED: begin
                arr_a = skew_out;
                if (tmr == '0) state_nx = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (arr_done) state_nx = chain ? S_WAIT_ARR : S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                res_data  = r_buf[IW'(out_k)];
                res_last  = (out_k == CNT_NM1);
                if (out_last_hs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Result slot update: capture in arrival order, drop overflow, zero slots an early arr_done left unfilled.
    always_comb begin
        for (int k = 0; k < N; k++) r_buf_nx[k] = r_buf[k];
        cap_cnt_nx = cap_cnt;
        cap_ovf    = 1'b0;
        if (cap_en) begin
            if (cap_cnt < CNT_N) begin
                r_buf_nx[IW'(cap_cnt)] = arr_y;
                cap_cnt_nx             = cap_cnt + CW'(1);
            end else begin
                cap_ovf = 1'b1;
            end
        end
        if (done_cap) begin
            for (int k = 0; k < N; k++) begin
                if (CW'(k) >= cap_cnt_nx) r_buf_nx[k] = '0;
            end
        end
    end

    // Data storage; contents are qualified by fill counters, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_hs) w_buf[IW'(w_cnt)] <= ld_w_data;
        if (a_hs) a_buf[IW'(a_cnt)] <= ld_a_data;
        for (int k = 0; k < N; k++) r_buf[k] <= r_buf_nx[k];
        if (chain) begin
            for (int k = 0; k < N; k++) a_buf[k] <= r_buf_nx[k];
        end
    end

    // Fill counters, phase timer, capture/output indices, pass count and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_cnt       <= '0;
            a_cnt       <= '0;
            tmr         <= '0;
            cap_cnt     <= '0;
            out_k       <= '0;
            passes_left <= '0;
            err_q       <= 1'b0;
        end else begin
            if (w_hs) w_cnt <= w_cnt + CW'(1);
            if (a_hs) a_cnt <= a_cnt + CW'(1);

            if (go_ok) begin
                passes_left <= (cfg_passes == '0) ? PW'(1) : cfg_passes;
                err_q       <= 1'b0;
            end else if (cap_ovf || done_early || done_short) begin
                err_q <= 1'b1;
            end

            case (state)
                S_WAIT_ARR: if (arr_ready) tmr <= CNT_NM1;
                S_W_FEED:   tmr <= (tmr == '0) ? CNT_2NM1 : tmr - CW'(1);
                S_A_FEED:   if (tmr != '0) tmr <= tmr - CW'(1);
                default:    ;
            endcase

            cap_cnt <= done_cap ? '0 : cap_cnt_nx;
            if (chain) passes_left <= passes_left - PW'(1);

            if (res_hs) out_k <= (out_k == CNT_NM1) ? '0 : out_k + CW'(1);

            // Buffers are consumed once the host has taken the last result.
            if (out_last_hs) begin
                w_cnt <= '0;
                a_cnt <= '0;
            end
        end
    end

    assign err = err_q;

endmodule
